// File: rtl/uart_rx_frame.sv
// Parametrised UART receiver: configurable data width, parity and stop bits, with
// false-start rejection, parity/framing flags and break recovery. Optional macro: UART_RX_MAJORITY_EN.
module uart_rx_frame #(
   parameter int CLKS_PER_BIT = 217,
   parameter int DATA_BITS    = 8,
   parameter int PARITY_MODE  = 0,
   parameter int STOP_BITS    = 1
) (
   input  logic                 i_Clock,
   input  logic                 i_Reset,
   input  logic                 i_RX_Serial,
   output logic                 o_RX_DV,
   output logic [DATA_BITS-1:0] o_RX_Byte,
   output logic                 o_Parity_Err,
   output logic                 o_Frame_Err,
   output logic                 o_Busy
);

   localparam int CW  = $clog2(CLKS_PER_BIT);
   localparam int IW  = $clog2(DATA_BITS);
   localparam int MID = (CLKS_PER_BIT - 1) / 2;
   localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

   typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, WAIT_IDLE} state_e;

   state_e               state_q, state_d;
   logic                 meta_q, sync_q;
   logic [CW-1:0]        cnt_q, cnt_d;
   logic [IW-1:0]        idx_q, idx_d;
   logic                 stop_q, stop_d;
   logic [DATA_BITS-1:0] data_q, data_d;
   logic                 pbit_q, pbit_d;
   logic                 facc_q, facc_d;
   logic                 dv_q, dv_d;
   logic [DATA_BITS-1:0] byte_q, byte_d;
   logic                 perr_q, perr_d;
   logic                 ferr_q, ferr_d;
   logic                 bit_s, tick, par_x, perr_calc;

`ifdef UART_RX_MAJORITY_EN
   localparam int SAMP = MID + 1;
   logic [1:0] hist_q;

   always_ff @(posedge i_Clock or posedge i_Reset) begin
      if (i_Reset) hist_q <= '1;
      else         hist_q <= {hist_q[0], sync_q};
   end

   // hist_q holds the two previous samples, so the decision at MID+1 votes over MID-1..MID+1
   assign bit_s = (hist_q[1] & hist_q[0]) | (hist_q[1] & sync_q) | (hist_q[0] & sync_q);
`else
   localparam int SAMP = MID;
   assign bit_s = sync_q;
`endif

   // START decides at the half-bit point; later states decide one full bit period after the previous decision
   assign tick = (state_q == START) ? (cnt_q == CW'(SAMP)) : (cnt_q == LAST);

   assign par_x     = (^data_q) ^ pbit_q;
   assign perr_calc = (PARITY_MODE == 1) ? par_x : (PARITY_MODE == 2) ? ~par_x : 1'b0;

   always_ff @(posedge i_Clock or posedge i_Reset) begin
      if (i_Reset) begin
         meta_q  <= 1'b1;
         sync_q  <= 1'b1;
         state_q <= IDLE;
         cnt_q   <= '0;
         idx_q   <= '0;
         stop_q  <= 1'b0;
         data_q  <= '0;
         pbit_q  <= 1'b0;
         facc_q  <= 1'b0;
         dv_q    <= 1'b0;
         byte_q  <= '0;
         perr_q  <= 1'b0;
         ferr_q  <= 1'b0;
      end else begin
         meta_q  <= i_RX_Serial;
         sync_q  <= meta_q;
         state_q <= state_d;
         cnt_q   <= cnt_d;
         idx_q   <= idx_d;
         stop_q  <= stop_d;
         data_q  <= data_d;
         pbit_q  <= pbit_d;
         facc_q  <= facc_d;
         dv_q    <= dv_d;
         byte_q  <= byte_d;
         perr_q  <= perr_d;
         ferr_q  <= ferr_d;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q + CW'(1);
      idx_d   = idx_q;
      stop_d  = stop_q;
      data_d  = data_q;
      pbit_d  = pbit_q;
      facc_d  = facc_q;
      dv_d    = 1'b0;
      byte_d  = byte_q;
      perr_d  = perr_q;
      ferr_d  = ferr_q;
      case (state_q)
         IDLE: begin
            cnt_d = '0;
            if (!sync_q) state_d = START;
         end
         START: begin
            if (tick) begin
               cnt_d = '0;
               if (bit_s) begin
                  state_d = IDLE;
               end else begin
                  state_d = DATA;
                  idx_d   = '0;
                  facc_d  = 1'b0;
               end
            end
         end
         DATA: begin
            if (tick) begin
               cnt_d         = '0;
               data_d[idx_q] = bit_s;
               if (idx_q == IW'(DATA_BITS - 1)) begin
                  state_d = (PARITY_MODE != 0) ? PARITY : STOP;
                  stop_d  = 1'b0;
               end else begin
                  idx_d = idx_q + IW'(1);
               end
            end
         end
         PARITY: begin
            if (tick) begin
               cnt_d   = '0;
               pbit_d  = bit_s;
               state_d = STOP;
               stop_d  = 1'b0;
            end
         end
         STOP: begin
            if (tick) begin
               cnt_d = '0;
               if (stop_q == 1'(STOP_BITS - 1)) begin
                  dv_d    = 1'b1;
                  byte_d  = data_q;
                  perr_d  = perr_calc;
                  ferr_d  = facc_q | ~bit_s;
                  state_d = bit_s ? IDLE : WAIT_IDLE;
               end else begin
                  facc_d = facc_q | ~bit_s;
                  stop_d = 1'b1;
               end
            end
         end
         WAIT_IDLE: begin
            if (!sync_q) begin
               cnt_d = '0;
            end else if (cnt_q == LAST) begin
               cnt_d   = '0;
               state_d = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
            cnt_d   = '0;
         end
      endcase
   end

   assign o_RX_DV      = dv_q;
   assign o_RX_Byte    = byte_q;
   assign o_Parity_Err = perr_q;
   assign o_Frame_Err  = ferr_q;
   assign o_Busy       = (state_q != IDLE);

endmodule

// File: doc/uart_rx_frame.md
Name: uart_rx_frame

Overview:
Parametrised UART receiver, next generation of the fixed 8N1 receiver. Data width, parity mode and stop-bit count are configurable. Adds false-start rejection, parity and framing error flags, and break recovery. Sits between the external RX pin and the byte-stream consumer; pairs with the existing transmitter in loopback benches.

Parameters:
CLKS_PER_BIT, 217, clocks per bit period (integer >= 8).
DATA_BITS, 8, data bits per frame (5..9), LSB first.
PARITY_MODE, 0, 0 = none, 1 = even, 2 = odd.
STOP_BITS, 1, stop bits per frame (1 or 2).

Ports:
i_Clock  input  1  system clock
i_Reset  input  1  asynchronous reset, active-high
i_RX_Serial  input  1  asynchronous serial line, idle high
o_RX_DV  output  1  one-cycle pulse: frame complete; outputs below valid
o_RX_Byte  output  DATA_BITS  received data, held until next o_RX_DV
o_Parity_Err  output  1  parity mismatch for the last frame, held with o_RX_Byte
o_Frame_Err  output  1  a stop bit sampled low in the last frame, held with o_RX_Byte
o_Busy  output  1  high from start-bit detection until return to IDLE

Behaviour:
- Reset: one clock; reset is asynchronous and active-high. While i_Reset is high, all outputs are 0, the FSM is in IDLE, counters are 0, and both synchronizer flops are 1. Asserting reset mid-frame aborts the frame with no o_RX_DV.
- Input path: 2-flop synchronizer, always present, which adds 2 cycles of latency. All sampling uses the synchronized value.
- Bit counter: width $clog2(CLKS_PER_BIT). MID = (CLKS_PER_BIT-1)/2, integer floor.
- FSM states: IDLE, START, DATA, PARITY, STOP, WAIT_IDLE.
- IDLE: sync line low -> START, clear counter, o_Busy=1.
- START: at count MID, sample the line. High = false start -> IDLE, no DV. Low -> DATA, counter reset, bit index 0.
- DATA: sample every CLKS_PER_BIT clocks, so samples land at bit centres. Shift into bit[index]. After index DATA_BITS-1 -> PARITY if PARITY_MODE != 0, else STOP.
- PARITY: sample one bit. Even: error if the XOR of data bits and parity bit is 1. Odd: error if that XOR is 0.
- STOP: sample STOP_BITS bits. Any low sample sets the frame-error flag. On the cycle after the last stop sample:
  - o_RX_DV=1 for exactly one cycle.
  - o_RX_Byte, o_Parity_Err and o_Frame_Err update in that same cycle.
  - Data is delivered even when errors are flagged.
- After STOP: if the last stop sample was high -> IDLE. Otherwise (frame error or break) -> WAIT_IDLE.
- WAIT_IDLE: remain until the sync line has been high for one full CLKS_PER_BIT, then -> IDLE. Prevents re-triggering inside a break.
- o_Busy deasserts on entry to IDLE. Back-to-back frames with a minimum 1-bit idle gap are received without loss; a new start edge is accepted on the first IDLE cycle.
- Error flags with PARITY_MODE=0: o_Parity_Err is constant 0.
- Unused state encodings -> IDLE.

Optional Feature:
Macro UART_RX_MAJORITY_EN.
- Defined: each sample point (start, data, parity, stop) takes 3 samples at counts MID-1, MID and MID+1. The bit value is the 2-of-3 majority, and the decision is registered at MID+1. The sample point shifts one cycle later; o_RX_DV timing moves by +1 cycle relative to the undefined case.
- Undefined: single sample at MID, no extra logic.

Test Plan:
- CLKS_PER_BIT=16, 8N1, send 0x3F then 0xA5 with a 1-bit gap -> two o_RX_DV pulses, bytes 0x3F and 0xA5, both error flags 0, o_Busy low between frames.
- PARITY_MODE=1, DATA_BITS=7, send 0x55 with parity bit 0, then 0x55 with parity bit 1 -> first frame o_Parity_Err=0, second o_Parity_Err=1, o_RX_Byte=0x55 in both.
- STOP_BITS=2, second stop bit driven low on 0x81 -> o_RX_DV with o_RX_Byte=0x81 and o_Frame_Err=1. Next valid frame 0x12 -> o_Frame_Err=0.
- Line low for 3 clocks (< MID) then high -> no o_RX_DV; o_Busy pulses then returns to 0 by count MID+1.
- 20-bit break (line low), then release, then send 0x7E -> one DV with 0x00 and o_Frame_Err=1. No further DV during the break. 0x7E is received correctly after one idle bit.
- Assert i_Reset during DATA bit 4 of 0xC3, release, then send 0x3C -> no DV for the aborted frame; all outputs 0 during reset; next DV carries 0x3C. With UART_RX_MAJORITY_EN defined, a 1-cycle glitch at MID on a data bit does not corrupt that bit.
